steer_sense_dp: RTL and testbench

- Datapath and timer that produce the rider-detection qualifiers consumed by the steering-enable state machine.
- Registers left/right load-cell samples from the A2D interface on each valid strobe and computes the following flags:
  - sum_gt_min / sum_lt_min, with hysteresis.
  - diff_gt_1_4 and diff_gt_15_16.
- Owns the settle timer: clears it on clr_tmr and reports tmr_full.
- Sits between the A2D interface and the steering-enable state machine.

---
 rtl/steer_sense_if.sv | 25 ++
 rtl/steer_sense_dp.sv | 106 ++++++++++
 tb/tb_steer_sense_dp.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/steer_sense_if.sv
// Bundle between the A2D front end, the rider-sense datapath and the
// steering-enable state machine.
interface steer_sense_if;
    logic        vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        clr_tmr;
    logic        tmr_full;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    modport master (
        output vld, lft_ld, rght_ld, clr_tmr,
        input  tmr_full, sum_gt_min, sum_lt_min,
        input  diff_gt_1_4, diff_gt_15_16
    );

    modport slave (
        input  vld, lft_ld, rght_ld, clr_tmr,
        output tmr_full, sum_gt_min, sum_lt_min,
        output diff_gt_1_4, diff_gt_15_16
    );
endinterface

// File: rtl/steer_sense_dp.sv
// Rider-detection qualifiers and settle timer for steering enable.
// Optional LD_FILTER_EN adds a per-channel IIR ahead of the flags.
module steer_sense_dp #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter logic [11:0] HYSTERESIS       = 12'h040,
    parameter bit          FAST_SIM         = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    steer_sense_if.slave bus
);

    localparam logic [12:0] SUM_HI =
        {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
    localparam logic [12:0] SUM_LO =
        {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};
    localparam logic [25:0] TMR_LIM =
        FAST_SIM ? 26'h0007FFF : 26'h3FFFFFF;

    logic [11:0] src_l;
    logic [11:0] src_r;
    logic        upd;

`ifdef LD_FILTER_EN
    logic [11:0] filt_l;
    logic [11:0] filt_r;
    logic        primed;
    logic        vld_d;

    function automatic logic [11:0] iir(
        input logic [11:0] f,
        input logic [11:0] s
    );
        logic [13:0] acc;
        acc = ({2'b00, f} * 14'd3) + {2'b00, s};
        return acc[13:2];
    endfunction

    // First strobe after reset seeds the filter with the raw sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_l <= '0;
            filt_r <= '0;
            primed <= 1'b0;
            vld_d  <= 1'b0;
        end else begin
            vld_d <= bus.vld;
            if (bus.vld) begin
                primed <= 1'b1;
                filt_l <= primed ? iir(filt_l, bus.lft_ld) : bus.lft_ld;
                filt_r <= primed ? iir(filt_r, bus.rght_ld) : bus.rght_ld;
            end
        end
    end

    assign src_l = filt_l;
    assign src_r = filt_r;
    assign upd   = vld_d;
`else
    assign src_l = bus.lft_ld;
    assign src_r = bus.rght_ld;
    assign upd   = bus.vld;
`endif

    logic [12:0] sum;
    logic [11:0] diff;
    logic [12:0] qtr_th;
    logic [12:0] ff_th;

    always_comb begin
        sum    = {1'b0, src_l} + {1'b0, src_r};
        diff   = (src_l >= src_r) ? (src_l - src_r) : (src_r - src_l);
        qtr_th = sum >> 2;
        ff_th  = sum - (sum >> 4);
    end

    // Empty platform reads as rider off until the first sample lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum_gt_min    <= 1'b0;
            bus.sum_lt_min    <= 1'b1;
            bus.diff_gt_1_4   <= 1'b0;
            bus.diff_gt_15_16 <= 1'b0;
        end else if (upd) begin
            bus.sum_gt_min    <= sum > SUM_HI;
            bus.sum_lt_min    <= sum < SUM_LO;
            bus.diff_gt_1_4   <= {1'b0, diff} > qtr_th;
            bus.diff_gt_15_16 <= {1'b0, diff} > ff_th;
        end
    end

    logic [25:0] tmr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_cnt <= '0;
        end else if (bus.clr_tmr) begin
            tmr_cnt <= '0;
        end else if (tmr_cnt != TMR_LIM) begin
            tmr_cnt <= tmr_cnt + 26'd1;
        end
    end

    assign bus.tmr_full = (tmr_cnt == TMR_LIM);

endmodule

// File: tb/tb_steer_sense_dp.sv
// Directed and randomized checks of steer_sense_dp against an
// arithmetic reference model of the rider-sense rules.
module tb_steer_sense_dp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    steer_sense_if bus ();

    steer_sense_dp #(
        .MIN_RIDER_WEIGHT(12'h200),
        .HYSTERESIS      (12'h040),
        .FAST_SIM        (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;
    int fl     = 0;
    int fr     = 0;
    bit first  = 1'b1;

    logic [3:0] obs;
    assign obs = {bus.sum_gt_min, bus.sum_lt_min,
                  bus.diff_gt_1_4, bus.diff_gt_15_16};

    // Flags from the rules: band 0x200 +/- 0x40, diff vs sum/4 and 15/16.
    function automatic logic [3:0] ref_flags(int l, int r);
        int s;
        int d;
        s = l + r;
        d = (l > r) ? l - r : r - l;
        return {s > 576, s < 448, d > s / 4, d > s - s / 16};
    endfunction

    task automatic chk(string tag, logic [3:0] o, logic [3:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s got %b exp %b", tag, o, e);
    endtask

    task automatic sample(string tag, int l, int r);
        logic [3:0] exp_f;
`ifdef LD_FILTER_EN
        if (first) begin
            fl = l;
            fr = r;
        end else begin
            fl = (3 * fl + l) / 4;
            fr = (3 * fr + r) / 4;
        end
        first = 1'b0;
`else
        fl = l;
        fr = r;
`endif
        exp_f = ref_flags(fl, fr);
        bus.vld     = 1'b1;
        bus.lft_ld  = 12'(l);
        bus.rght_ld = 12'(r);
        @(negedge clk);
        bus.vld     = 1'b0;
        bus.lft_ld  = 12'($urandom);
        bus.rght_ld = 12'($urandom);
`ifdef LD_FILTER_EN
        @(negedge clk);
`endif
        chk(tag, obs, exp_f);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, obs, exp_f);
    endtask

    initial begin
        int l;
        int r;
        int ql;
        int qr;
        bus.vld     = 1'b0;
        bus.lft_ld  = '0;
        bus.rght_ld = '0;
        bus.clr_tmr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_flags", obs, 4'b0100);
        chk("rst_tmr", {3'b0, bus.tmr_full}, 4'b0000);

        sample("gt_min", 12'h130, 12'h120);
        sample("in_band", 12'h100, 12'h100);
        sample("lt_min", 12'h0E0, 12'h0D0);
        sample("diff_q", 12'h300, 12'h020);
        sample("diff_ff", 12'h320, 12'h000);
        sample("zero", 0, 0);
        sample("band_hi", 12'h120, 12'h120);
        sample("band_lo", 12'h0E0, 12'h0E0);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                l = $urandom_range(0, 12'hFFF);
                r = $urandom_range(0, 12'hFFF);
            end else begin
                l = $urandom_range(12'h0C0, 12'h140);
                r = $urandom_range(12'h0C0, 12'h140);
            end
            sample("rand", l, r);
        end

`ifndef LD_FILTER_EN
        // Back-to-back strobes: each edge reflects the previous sample.
        ql = $urandom_range(0, 12'h3FF);
        qr = $urandom_range(0, 12'h3FF);
        bus.vld     = 1'b1;
        bus.lft_ld  = 12'(ql);
        bus.rght_ld = 12'(qr);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stream", obs, ref_flags(ql, qr));
            ql = $urandom_range(0, 12'h3FF);
            qr = $urandom_range(0, 12'h3FF);
            bus.lft_ld  = 12'(ql);
            bus.rght_ld = 12'(qr);
        end
        bus.vld = 1'b0;
        fl = 0;
        fr = 0;
        @(negedge clk);
`endif

        sample("pre_rst", 12'h300, 12'h100);
        rst_n = 1'b0;
        #1;
        chk("arst_flags", obs, 4'b0100);
        chk("arst_tmr", {3'b0, bus.tmr_full}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        first = 1'b1;
        fl = 0;
        fr = 0;
        bus.lft_ld  = 12'h300;
        bus.rght_ld = 12'h100;
        repeat (3) @(negedge clk);
        chk("no_upd", obs, 4'b0100);
        sample("post_rst", 12'h080, 12'h700);

        bus.clr_tmr = 1'b1;
        @(negedge clk);
        bus.clr_tmr = 1'b0;
        repeat (19999) @(negedge clk);
        chk("tmr_20k", {3'b0, bus.tmr_full}, 4'b0000);
        bus.clr_tmr = 1'b1;
        @(negedge clk);
        bus.clr_tmr = 1'b0;
        repeat (32766) @(negedge clk);
        chk("tmr_m1", {3'b0, bus.tmr_full}, 4'b0000);
        @(negedge clk);
        chk("tmr_full", {3'b0, bus.tmr_full}, 4'b0001);
        repeat (5) @(negedge clk);
        chk("tmr_sat", {3'b0, bus.tmr_full}, 4'b0001);

        bus.clr_tmr = 1'b1;
        @(negedge clk);
        chk("tmr_clr", {3'b0, bus.tmr_full}, 4'b0000);
        sample("vld_clr", 12'h200, 12'h050);
        chk("tmr_held", {3'b0, bus.tmr_full}, 4'b0000);
        bus.clr_tmr = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmr_run", {3'b0, bus.tmr_full}, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
